// File: rtl/nth_last_sym_matcher.sv
// Streaming matcher for (1|0)* . S . (1|0){REPEAT}: flags when the symbol REPEAT back equals S.
// Optional saturating match counter is compiled in with `define REGEX_MATCH_CNT_EN.
module nth_last_sym_matcher #(
  parameter int unsigned REPEAT = 20,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i,
  input  logic             i_c,
  input  logic             i_valid,
  input  logic             sym,
  input  logic             clear,
  output logic             o,
  output logic             o_valid
`ifdef REGEX_MATCH_CNT_EN
  ,
  output logic [CNT_W-1:0] match_cnt
`endif
);

  logic [REPEAT:0] tok_q, tok_d;
  logic [REPEAT:0] tok_shift;
  logic            o_valid_q, o_valid_d;
  logic            tok_in;

  // A token enters only when the leading state is enabled and the symbol matches the anchor.
  assign tok_in = i & ~(i_c ^ sym);

  generate
    if (REPEAT == 0) begin : g_no_shift
      assign tok_shift = tok_in;
    end else begin : g_shift
      assign tok_shift = {tok_q[REPEAT-1:0], tok_in};
    end
  endgenerate

  always_comb begin
    tok_d     = tok_q;
    o_valid_d = 1'b0;
    if (clear) begin
      tok_d = '0;
    end else if (i_valid) begin
      tok_d     = tok_shift;
      o_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tok_q     <= '0;
      o_valid_q <= 1'b0;
    end else begin
      tok_q     <= tok_d;
      o_valid_q <= o_valid_d;
    end
  end

  // The last token position is the registered match flag; it moves and clears with the chain.
  assign o       = tok_q[REPEAT];
  assign o_valid = o_valid_q;

`ifdef REGEX_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (i_valid && tok_shift[REPEAT] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign match_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_nth_last_sym_matcher.sv
// Bench for nth_last_sym_matcher: three depths driven in parallel, checked against a symbol-history model.
module tb_nth_last_sym_matcher;

  logic clk = 1'b0;
  logic reset, i, i_c, i_valid, sym, clear;
  logic o2, v2, o20, v20, o0, v0;
`ifdef REGEX_MATCH_CNT_EN
  logic [15:0] cnt2, cnt20;
  logic [1:0]  cnt0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nth_last_sym_matcher #(.REPEAT(2), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .i(i), .i_c(i_c), .i_valid(i_valid), .sym(sym),
    .clear(clear), .o(o2), .o_valid(v2)
`ifdef REGEX_MATCH_CNT_EN
    , .match_cnt(cnt2)
`endif
  );

  nth_last_sym_matcher #(.REPEAT(20), .CNT_W(16)) u20 (
    .clk(clk), .reset(reset), .i(i), .i_c(i_c), .i_valid(i_valid), .sym(sym),
    .clear(clear), .o(o20), .o_valid(v20)
`ifdef REGEX_MATCH_CNT_EN
    , .match_cnt(cnt20)
`endif
  );

  nth_last_sym_matcher #(.REPEAT(0), .CNT_W(2)) u0 (
    .clk(clk), .reset(reset), .i(i), .i_c(i_c), .i_valid(i_valid), .sym(sym),
    .clear(clear), .o(o0), .o_valid(v0)
`ifdef REGEX_MATCH_CNT_EN
    , .match_cnt(cnt0)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Reference model: hist[k] says whether the k-th most recent consumed symbol carried a token
  // (i was high and the symbol equalled the anchor at that time).
  bit hist[$];
  bit e_o2, e_o20, e_o0, e_v;
  int e_c2, e_c20, e_c0;

  function automatic bit tok_at(int back);
    return (hist.size() > back) ? hist[back] : 1'b0;
  endfunction

  always @(posedge clk) begin
    if (!reset || clear) begin
      hist.delete();
      e_o2 = 0; e_o20 = 0; e_o0 = 0; e_v = 0;
      e_c2 = 0; e_c20 = 0; e_c0 = 0;
    end else if (i_valid) begin
      hist.push_front(i && (i_c == sym));
      if (hist.size() > 300) void'(hist.pop_back());
      e_o2 = tok_at(2); e_o20 = tok_at(20); e_o0 = tok_at(0); e_v = 1;
      if (e_o2  && e_c2  < 65535) e_c2++;
      if (e_o20 && e_c20 < 65535) e_c20++;
      if (e_o0  && e_c0  < 3)     e_c0++;
    end else begin
      e_v = 0;
    end
    #1;
    chk("o_r2", 32'(o2), 32'(e_o2));
    chk("ovalid_r2", 32'(v2), 32'(e_v));
    chk("o_r20", 32'(o20), 32'(e_o20));
    chk("ovalid_r20", 32'(v20), 32'(e_v));
    chk("o_r0", 32'(o0), 32'(e_o0));
    chk("ovalid_r0", 32'(v0), 32'(e_v));
`ifdef REGEX_MATCH_CNT_EN
    chk("cnt_r2", 32'(cnt2), 32'(e_c2));
    chk("cnt_r20", 32'(cnt20), 32'(e_c20));
    chk("cnt_r0", 32'(cnt0), 32'(e_c0));
`endif
  end

  task automatic drive(input logic v, input logic ii, input logic c, input logic s, input logic cl);
    i_valid = v; i = ii; i_c = c; sym = s; clear = cl;
    @(posedge clk);
    #2;
  endtask

  task automatic do_clear();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    i_valid = 1'b0; clear = 1'b0;
  endtask

  logic [5:0] t1_str, t1_exp;
  logic [3:0] t2_str, t2_exp;
  logic [2:0] t2b_exp;
  logic [1:0] t6_cnt [5];

  initial begin
    reset = 1'b0; i = 0; i_c = 0; i_valid = 0; sym = 0; clear = 0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_o2", 32'(o2), 32'd0);
    chk("reset_ovalid2", 32'(v2), 32'd0);
    reset = 1'b1;

    // REPEAT=2, sym=1: stream 1,0,0,1,1,0 -> 0,0,1,0,0,1
    do_clear();
    t1_str = 6'b100110; t1_exp = 6'b001001;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 1'b1, t1_str[5-k], 1'b1, 1'b0);
      chk("t1_ovalid", 32'(v2), 32'd1);
      chk("t1_o", 32'(o2), 32'(t1_exp[5-k]));
    end

    // REPEAT=2, sym=0: 0,1,1,0 -> 0,0,1,0; then sym=1: 1,1,1 -> 0,1,1
    do_clear();
    t2_str = 4'b0110; t2_exp = 4'b0010; t2b_exp = 3'b011;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b1, t2_str[3-k], 1'b0, 1'b0);
      chk("t2_o", 32'(o2), 32'(t2_exp[3-k]));
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t2b_o", 32'(o2), 32'(t2b_exp[2-k]));
    end

    // REPEAT=20: single anchor then 20 non-token symbols
    do_clear();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_o_r0", 32'(o0), 32'd1);
    for (int k = 2; k <= 21; k++) begin
      drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("t3_o_r20", 32'(o20), (k == 21) ? 32'd1 : 32'd0);
    end
`ifdef REGEX_MATCH_CNT_EN
    chk("t3_cnt_r20", 32'(cnt20), 32'd1);
`endif

    // REPEAT=2 with idle gaps between strobes
    do_clear();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 1'b1, (k == 0) ? 1'b1 : 1'b0, 1'b1, 1'b0);
      chk("t4_ovalid", 32'(v2), 32'd1);
      chk("t4_o", 32'(o2), (k == 2) ? 32'd1 : 32'd0);
      if (k < 2) begin
        repeat (3) begin
          drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
          chk("t4_gap_ovalid", 32'(v2), 32'd0);
          chk("t4_gap_o", 32'(o2), 32'd0);
        end
      end
    end

    // clear on the same cycle as a strobe discards it
    do_clear();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t5_o", 32'(o2), 32'd0);
    chk("t5_ovalid", 32'(v2), 32'd0);
`ifdef REGEX_MATCH_CNT_EN
    chk("t5_cnt", 32'(cnt0), 32'd0);
`endif
    repeat (2) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t5_after_o", 32'(o2), 32'd0);
    end

    // REPEAT=0, CNT_W=2 saturation, then async reset mid-cycle
    do_clear();
    t6_cnt[0] = 2'd1; t6_cnt[1] = 2'd2; t6_cnt[2] = 2'd3; t6_cnt[3] = 2'd3; t6_cnt[4] = 2'd3;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
      chk("t6_o_r0", 32'(o0), 32'd1);
`ifdef REGEX_MATCH_CNT_EN
      chk("t6_cnt_r0", 32'(cnt0), 32'(t6_cnt[k]));
`endif
    end
    i_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("t6_async_o0", 32'(o0), 32'd0);
    chk("t6_async_v0", 32'(v0), 32'd0);
    chk("t6_async_o2", 32'(o2), 32'd0);
`ifdef REGEX_MATCH_CNT_EN
    chk("t6_async_cnt0", 32'(cnt0), 32'd0);
`endif
    @(posedge clk);
    #2 reset = 1'b1;

    // randomized phase
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) reset = 1'b0;
      drive(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0), 1'($urandom),
            1'($urandom_range(0, 7) != 0), ($urandom_range(0, 39) == 0));
      reset = 1'b1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
